// File: rtl/banner_overlay_gen.sv
// Sprite-banner overlay generator for the HDMI piece controller.
// Places one of NUM_MSG banners from an external synchronous ROM at (X0, Y0),
// optionally scaled by 2^SCALE_LOG2, and emits overlay_on plus 4-bit RGB with a
// fixed three-register latency (address reg -> ROM reg -> output reg).
// Optional feature macro: OVERLAY_BLINK_EN adds a frame-based blink counter;
// when undefined the banner is always visible and BLINK_FRAMES is unused.
module banner_overlay_gen #(
    parameter int unsigned X0           = 560,
    parameter int unsigned Y0           = 434,
    parameter int unsigned W            = 80,
    parameter int unsigned H            = 45,
    parameter int unsigned SCALE_LOG2   = 0,
    parameter int unsigned NUM_MSG      = 4,
    parameter int unsigned BLINK_FRAMES = 30,
    parameter logic [47:0] PALETTE      = 48'h0,
    parameter int unsigned AW           = $clog2(NUM_MSG * W * H)
) (
    input  logic                       vga_clk,
    input  logic                       reset,
    input  logic [9:0]                 DrawX,
    input  logic [9:0]                 DrawY,
    input  logic                       blank,
    input  logic                       msg_req,
    input  logic                       msg_show,
    input  logic [$clog2(NUM_MSG)-1:0] msg_sel,
    output logic                       msg_ack,
    output logic [AW-1:0]              rom_addr,
    input  logic [1:0]                 rom_data,
    output logic                       overlay_on,
    output logic [3:0]                 red,
    output logic [3:0]                 green,
    output logic [3:0]                 blue
);

    localparam int unsigned SW  = $clog2(NUM_MSG);
    localparam int unsigned SW1 = SW + 1;
    localparam int unsigned AF  = AW + 1;

    // Box bounds at 11 bits so X0 + width cannot wrap against a 10-bit coordinate.
    localparam logic [10:0] X_LO  = 11'(X0);
    localparam logic [10:0] X_HI  = 11'(X0 + (W << SCALE_LOG2));
    localparam logic [10:0] Y_LO  = 11'(Y0);
    localparam logic [10:0] Y_HI  = 11'(Y0 + (H << SCALE_LOG2));
    localparam logic [9:0]  X_OFF = 10'(X0);
    localparam logic [9:0]  Y_OFF = 10'(Y0);

    logic              frame_start;
    logic              in_box;
    logic              req_valid;
    logic              visible;
    logic [9:0]        dx, dy, lx, ly;
    logic [AW:0]       addr_full;
    logic [11:0]       texel_rgb;

    logic [SW-1:0]     cur_msg_q;
    logic              shown_q;
    logic              msg_ack_q;
    logic [AW-1:0]     rom_addr_q;
    logic              s1_valid_q, s1_gate_q;
    logic              s2_valid_q, s2_gate_q;
    logic              overlay_on_q;
    logic [11:0]       rgb_q;

    // Pixel decode: box test, texel coordinates and full-width ROM address.
    always_comb begin
        frame_start = (DrawX == 10'd0) && (DrawY == 10'd0);
        in_box      = ({1'b0, DrawX} >= X_LO) && ({1'b0, DrawX} < X_HI) &&
                      ({1'b0, DrawY} >= Y_LO) && ({1'b0, DrawY} < Y_HI);
        dx          = DrawX - X_OFF;
        dy          = DrawY - Y_OFF;
        lx          = dx >> SCALE_LOG2;
        ly          = dy >> SCALE_LOG2;
        addr_full   = AF'(cur_msg_q) * AF'(W * H) + AF'(ly) * AF'(W) + AF'(lx);
        req_valid   = ({1'b0, msg_sel} < SW1'(NUM_MSG));
    end

    // Address is computed one bit wide and truncated; the carry bit is dropped.
    logic unused_addr_msb;
    assign unused_addr_msb = addr_full[AW];

    // Message state: requests only take effect on the frame-start pixel.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            cur_msg_q <= '0;
            shown_q   <= 1'b0;
            msg_ack_q <= 1'b0;
        end else begin
            msg_ack_q <= frame_start & msg_req;
            if (frame_start && msg_req && req_valid) begin
                cur_msg_q <= msg_sel;
                shown_q   <= msg_show;
            end
        end
    end

`ifdef OVERLAY_BLINK_EN
    localparam int unsigned BW         = $clog2(2 * BLINK_FRAMES);
    localparam logic [BW-1:0] BLINK_HALF = BW'(BLINK_FRAMES);
    localparam logic [BW-1:0] BLINK_LAST = BW'(2 * BLINK_FRAMES - 1);

    logic [BW-1:0] blink_q;

    // Frame counter for blinking; restarts on every applied request.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            blink_q <= '0;
        end else if (frame_start) begin
            if (msg_req && req_valid) begin
                blink_q <= '0;
            end else if (blink_q == BLINK_LAST) begin
                blink_q <= '0;
            end else begin
                blink_q <= blink_q + 1'b1;
            end
        end
    end

    assign visible = (blink_q < BLINK_HALF);
`else
    assign visible = 1'b1;

    logic unused_blink;
    assign unused_blink = ^BLINK_FRAMES;
`endif

    // Stage 1: register ROM address and the per-pixel gating flags.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            rom_addr_q <= '0;
            s1_valid_q <= 1'b0;
            s1_gate_q  <= 1'b0;
        end else begin
            s1_valid_q <= 1'b1;
            s1_gate_q  <= blank & in_box & shown_q & visible;
            if (in_box) begin
                rom_addr_q <= addr_full[AW-1:0];
            end
        end
    end

    // Stage 2: carry flags alongside the ROM's own read register.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            s2_valid_q <= 1'b0;
            s2_gate_q  <= 1'b0;
        end else begin
            s2_valid_q <= s1_valid_q;
            s2_gate_q  <= s1_gate_q;
        end
    end

    // Palette lookup; index 0 is transparent so its entry is never used.
    always_comb begin
        texel_rgb = 12'h000;
        case (rom_data)
            2'd1:    texel_rgb = PALETTE[23:12];
            2'd2:    texel_rgb = PALETTE[35:24];
            2'd3:    texel_rgb = PALETTE[47:36];
            default: texel_rgb = 12'h000;
        endcase
    end

    // Stage 3: registered overlay enable and colour.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            overlay_on_q <= 1'b0;
            rgb_q        <= 12'h000;
        end else if (s2_valid_q && s2_gate_q && (rom_data != 2'd0)) begin
            overlay_on_q <= 1'b1;
            rgb_q        <= texel_rgb;
        end else begin
            overlay_on_q <= 1'b0;
            rgb_q        <= 12'h000;
        end
    end

    assign msg_ack    = msg_ack_q;
    assign rom_addr   = rom_addr_q;
    assign overlay_on = overlay_on_q;
    assign red        = rgb_q[11:8];
    assign green      = rgb_q[7:4];
    assign blue       = rgb_q[3:0];

endmodule

// File: tb/tb_banner_overlay_gen.sv
// Self-checking bench for banner_overlay_gen: small 16x10 raster, scaled 4x3
// sprite at (5,3), external ROM modelled as a synchronous array, and a
// behavioural model of the expected overlay stream and handshake.
module tb_banner_overlay_gen;

    localparam int unsigned X0  = 5;
    localparam int unsigned Y0  = 3;
    localparam int unsigned W   = 4;
    localparam int unsigned H   = 3;
    localparam int unsigned SC  = 1;
    localparam int unsigned NM  = 4;
    localparam int unsigned BF  = 2;
    localparam int unsigned AW  = $clog2(NM * W * H);
    localparam logic [47:0] PAL = {12'h0AF, 12'hF00, 12'h3C5, 12'h777};
    localparam int FW = 16;
    localparam int FH = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic [9:0]    DrawX, DrawY;
    logic          blank, msg_req, msg_show;
    logic [1:0]    msg_sel;
    logic          msg_ack;
    logic [AW-1:0] rom_addr;
    logic [1:0]    rom_data;
    logic          overlay_on;
    logic [3:0]    red, green, blue;

    logic [1:0]    rom [0:63];
    logic [47:0]   pal_v;

    typedef struct packed {
        logic        on;
        logic [11:0] rgb;
    } pix_t;

    // Model state
    int            m_msg;
    bit            m_shown;
    int            m_frames;
    pix_t          q[$];
    logic [AW-1:0] m_addr;
    bit            m_ack;

    int checks;
    int errors;
    int cnt;

    banner_overlay_gen #(
        .X0(X0), .Y0(Y0), .W(W), .H(H), .SCALE_LOG2(SC), .NUM_MSG(NM),
        .BLINK_FRAMES(BF), .PALETTE(PAL), .AW(AW)
    ) dut (
        .vga_clk   (clk),
        .reset     (reset),
        .DrawX     (DrawX),
        .DrawY     (DrawY),
        .blank     (blank),
        .msg_req   (msg_req),
        .msg_show  (msg_show),
        .msg_sel   (msg_sel),
        .msg_ack   (msg_ack),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .overlay_on(overlay_on),
        .red       (red),
        .green     (green),
        .blue      (blue)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: update the model from the inputs sampled at the edge, then compare.
    task automatic step();
        pix_t p, e;
        int   lx, ly, a, t;
        bit   inb, vis;
        @(posedge clk);
        e = '0;
        if (reset) begin
            m_msg = 0; m_shown = 0; m_frames = 0; m_addr = '0; m_ack = 0;
            q.delete();
            q.push_back('0);
            q.push_back('0);
        end else begin
            inb = (DrawX >= X0) && (DrawX < X0 + (W << SC)) &&
                  (DrawY >= Y0) && (DrawY < Y0 + (H << SC));
`ifdef OVERLAY_BLINK_EN
            vis = ((m_frames % (2 * BF)) < BF);
`else
            vis = 1'b1;
`endif
            p = '0;
            if (inb) begin
                lx = (int'(DrawX) - X0) >> SC;
                ly = (int'(DrawY) - Y0) >> SC;
                a  = m_msg * W * H + ly * W + lx;
                m_addr = a[AW-1:0];
                t = int'(rom[a]);
                if (blank && m_shown && vis && t != 0) begin
                    p.on  = 1'b1;
                    p.rgb = pal_v[t*12 +: 12];
                end
            end
            q.push_back(p);
            e = q.pop_front();
            m_ack = 0;
            if (DrawX == 0 && DrawY == 0) begin
                m_frames++;
                if (msg_req) begin
                    m_ack = 1;
                    if (int'(msg_sel) < NM) begin
                        m_msg = int'(msg_sel); m_shown = msg_show; m_frames = 0;
                    end
                end
            end
        end
        #1;
        check("model_overlay_on", overlay_on, e.on);
        check("model_rgb", {red, green, blue}, e.rgb);
        check("model_msg_ack", msg_ack, m_ack);
        check("model_rom_addr", rom_addr, m_addr);
    endtask

    task automatic px(input int x, input int y, input logic b);
        DrawX = 10'(x);
        DrawY = 10'(y);
        blank = b;
        step();
    endtask

    // Scan one full frame; in random mode blank and requests are randomised.
    task automatic scan_frame(input bit rnd, output int on_cnt);
        on_cnt = 0;
        for (int y = 0; y < FH; y++) begin
            for (int x = 0; x < FW; x++) begin
                DrawX = 10'(x);
                DrawY = 10'(y);
                blank = rnd ? ($urandom_range(0, 4) != 0) : 1'b1;
                if (rnd && y == 5 && x == 0 && !msg_req && $urandom_range(0, 2) == 0) begin
                    msg_req  = 1'b1;
                    msg_sel  = 2'($urandom_range(0, 3));
                    msg_show = ($urandom_range(0, 3) != 0);
                end
                step();
                if (overlay_on) on_cnt++;
                if (m_ack) msg_req = 1'b0;
            end
        end
    endtask

    initial begin
        bit exp_vis [5];
        checks = 0;
        errors = 0;
        pal_v  = PAL;
        for (int i = 0; i < 64; i++) rom[i] = 2'($urandom_range(0, 3));
        rom[33] = 2'd2;
        rom[24] = 2'd0;
        q.push_back('0);
        q.push_back('0);

        reset = 1'b1; DrawX = '0; DrawY = '0; blank = 1'b0;
        msg_req = 1'b0; msg_show = 1'b0; msg_sel = '0;
        repeat (3) step();
        check("reset_overlay_on", overlay_on, 0);
        check("reset_rgb", {red, green, blue}, 0);
        check("reset_rom_addr", rom_addr, 0);
        check("reset_msg_ack", msg_ack, 0);
        reset = 1'b0;

        // Handshake: mid-frame request waits for the frame-start pixel.
        msg_req = 1'b1; msg_sel = 2'd2; msg_show = 1'b1;
        px(3, 2, 1);  check("hs_no_ack_mid_a", msg_ack, 0);
        px(9, 6, 1);  check("hs_no_ack_mid_b", msg_ack, 0);
        px(0, 0, 1);  check("hs_ack", msg_ack, 1);
        msg_req = 1'b0;
        px(5, 3, 1);  check("hs_ack_one_cycle", msg_ack, 0);
                      check("base_addr_msg2", rom_addr, 24);
        px(7, 8, 1);  check("addr_7_8", rom_addr, 33);
        px(13, 8, 1); check("addr_hold_outside", rom_addr, 33);
                      check("transparent_on", overlay_on, 0);
                      check("transparent_rgb", {red, green, blue}, 0);
        px(4, 8, 1);  check("opaque_on", overlay_on, 1);
                      check("opaque_rgb", {red, green, blue}, 12'hF00);
        px(12, 9, 1); check("right_edge_off", overlay_on, 0);
        px(7, 8, 0);  check("left_edge_off", overlay_on, 0);
        px(7, 2, 1);  check("bottom_edge_off", overlay_on, 0);
        px(7, 2, 1);  check("blank_off", overlay_on, 0);

        // Reset mid-frame while the overlay is active.
        repeat (3) px(7, 8, 1);
        check("pre_reset_on", overlay_on, 1);
        reset = 1'b1; msg_req = 1'b1; msg_sel = 2'd3; msg_show = 1'b1;
        px(0, 0, 1);
        check("rst_mid_on", overlay_on, 0);
        check("rst_mid_rgb", {red, green, blue}, 0);
        check("rst_mid_addr", rom_addr, 0);
        check("rst_mid_ack", msg_ack, 0);
        px(0, 0, 1);  check("rst_req_no_ack", msg_ack, 0);
        reset = 1'b0; msg_req = 1'b0;
        scan_frame(1'b0, cnt);
        check("hidden_after_reset", cnt, 0);

        // Blink sequence over five frames after an applied request.
`ifdef OVERLAY_BLINK_EN
        exp_vis = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
`else
        exp_vis = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
        msg_req = 1'b1; msg_sel = 2'd2; msg_show = 1'b1;
        for (int f = 0; f < 5; f++) begin
            scan_frame(1'b0, cnt);
            check($sformatf("blink_frame_%0d", f), (cnt > 0), exp_vis[f]);
        end

        // Hide request.
        msg_req = 1'b1; msg_sel = 2'd1; msg_show = 1'b0;
        scan_frame(1'b0, cnt);
        check("hide_frame", cnt, 0);

        // Randomised frames against the model.
        for (int f = 0; f < 12; f++) scan_frame(1'b1, cnt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
